// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear sweep and busy scoreboard
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic [NRD*ADDR_W-1:0]  raddr,
    output logic [NRD*DATA_W-1:0]  rdata,
    output logic [NRD-1:0]         rbusy,
    input  logic [NWR-1:0]         wena,
    input  logic [NWR*ADDR_W-1:0]  waddr,
    input  logic [NWR*DATA_W-1:0]  wdata,
    input  logic [NWR-1:0]         wclr,
    input  logic                   sb_set,
    input  logic [ADDR_W-1:0]      sb_addr,
    output logic [(2**ADDR_W)-1:0] busy_vec,
    input  logic [ADDR_W-1:0]      ila_addr,
    output logic [DATA_W-1:0]      ila_data
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  clr_hit, set_hit;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              run;

    assign run = (state_q == S_RUN);

    // Sweep sequencing: one register zeroed per cycle, the last one hands over to RUN
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        if (state_q == S_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end
    end

    // Array next state: sweep zeroing in CLEAR, port writes in RUN (later port overrides)
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (!run) begin
            regs_d[ptr_q] = '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wena[i]) begin
                    regs_d[waddr[i*ADDR_W +: ADDR_W]] = wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scoreboard next state: clears from completing writes, then issue sets on top
    always_comb begin
        clr_hit = '0;
        set_hit = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wena[i] && wclr[i]) begin
                clr_hit[waddr[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (sb_set) begin
            set_hit[sb_addr] = 1'b1;
        end
        busy_d = run ? ((busy_q & ~clr_hit) | set_hit) : busy_q;
    end

    // Read ports: array value, optionally overridden by same-cycle writes to the same address
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            if (run) begin
                rdata[j*DATA_W +: DATA_W] = regs_q[raddr[j*ADDR_W +: ADDR_W]];
                rbusy[j] = busy_q[raddr[j*ADDR_W +: ADDR_W]];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NWR; i++) begin
                        if (wena[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W])) begin
                            rdata[j*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
                            if (wclr[i]) begin
                                rbusy[j] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Control state and scoreboard registers; reset restarts the sweep from address 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Register array; contents are only defined by the sweep, so no reset term here
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    assign ready    = ready_q;
    assign busy_vec = busy_q;
    assign ila_data = regs_q[ila_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized scoreboard bench for regfile_mp, bypass and non-bypass
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int D  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR*AW-1:0]  raddr;
    logic [NW-1:0]     wena, wclr;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic              sb_set;
    logic [AW-1:0]     sb_addr, ila_addr;

    logic              ready_b, ready_n;
    logic [NR*DW-1:0]  rdata_b, rdata_n;
    logic [NR-1:0]     rbusy_b, rbusy_n;
    logic [D-1:0]      busy_b, busy_n;
    logic [DW-1:0]     ila_b, ila_n;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ready(ready_b), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wena(wena), .waddr(waddr), .wdata(wdata), .wclr(wclr), .sb_set(sb_set),
        .sb_addr(sb_addr), .busy_vec(busy_b), .ila_addr(ila_addr), .ila_data(ila_b)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ready(ready_n), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .wena(wena), .waddr(waddr), .wdata(wdata), .wclr(wclr), .sb_set(sb_set),
        .sb_addr(sb_addr), .busy_vec(busy_n), .ila_addr(ila_addr), .ila_data(ila_n)
    );

    typedef struct {
        int          kind;
        int          dut;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: register contents, busy set, clear progress
    logic [DW-1:0] m_regs [D];
    logic [D-1:0]  m_known;
    logic [D-1:0]  m_busy;
    bit            m_run;
    bit            m_init;
    int            m_cnt;

    // What this cycle's inputs will do at the edge (valid only in RUN)
    logic [DW-1:0] n_regs [D];
    logic [D-1:0]  n_written;
    logic [D-1:0]  n_cleared;
    logic [D-1:0]  n_busy;

    task automatic compute_next();
        for (int r = 0; r < D; r++) n_regs[r] = m_regs[r];
        n_written = '0;
        n_cleared = '0;
        for (int i = 0; i < NW; i++) begin
            if (wena[i]) begin
                n_regs[waddr[i*AW +: AW]] = wdata[i*DW +: DW];
                n_written[waddr[i*AW +: AW]] = 1'b1;
                if (wclr[i]) n_cleared[waddr[i*AW +: AW]] = 1'b1;
            end
        end
        n_busy = m_busy & ~n_cleared;
        if (sb_set) n_busy[sb_addr] = 1'b1;
    endtask

    task automatic push(input int kind, input int d, input int idx, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.dut  = d;
        e.idx  = idx;
        e.val  = val;
        expq.push_back(e);
    endtask

    task automatic push_expects();
        logic [AW-1:0] ra;
        logic [31:0]   rd;
        logic          rb;
        compute_next();
        for (int d = 0; d < 2; d++) begin
            push(0, d, 0, {31'b0, m_run});
            push(1, d, 0, {16'b0, m_busy});
            for (int j = 0; j < NR; j++) begin
                ra = raddr[j*AW +: AW];
                rd = '0;
                rb = 1'b0;
                if (m_run) begin
                    // Bypassed reads see the post-edge value of anything written this cycle
                    rd = (d == 0 && n_written[ra]) ? n_regs[ra] : m_regs[ra];
                    rb = m_busy[ra] && !(d == 0 && n_cleared[ra]);
                end
                push(2, d, j, rd);
                push(3, d, j, {31'b0, rb});
            end
            if (m_known[ila_addr]) push(4, d, 0, m_regs[ila_addr]);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            m_busy = '0;
            m_init = 1'b1;
        end else if (!m_run) begin
            m_regs[m_cnt]  = '0;
            m_known[m_cnt] = 1'b1;
            m_cnt++;
            if (m_cnt == D) m_run = 1'b1;
        end else begin
            compute_next();
            for (int r = 0; r < D; r++) m_regs[r] = n_regs[r];
            m_busy = n_busy;
        end
    endtask

    task automatic cycle();
        if (!rst && m_init) push_expects();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, D - 1));
    endfunction

    task automatic idle_in();
        wena     = '0;
        wclr     = '0;
        waddr    = '0;
        wdata    = '0;
        sb_set   = 1'b0;
        sb_addr  = '0;
        raddr    = NR*AW'($urandom);
        ila_addr = AW'($urandom_range(0, D - 1));
    endtask

    task automatic rand_in();
        wena    = NW'($urandom);
        wclr    = NW'($urandom);
        for (int i = 0; i < NW; i++) begin
            waddr[i*AW +: AW] = pick_addr();
            wdata[i*DW +: DW] = $urandom;
        end
        for (int j = 0; j < NR; j++) raddr[j*AW +: AW] = pick_addr();
        sb_set   = ($urandom_range(0, 2) == 0);
        sb_addr  = pick_addr();
        ila_addr = AW'($urandom_range(0, D - 1));
    endtask

    function automatic logic [31:0] actual(input int kind, input int d, input int idx);
        case (kind)
            0:       return d != 0 ? {31'b0, ready_n} : {31'b0, ready_b};
            1:       return d != 0 ? {16'b0, busy_n} : {16'b0, busy_b};
            2:       return d != 0 ? rdata_n[idx*DW +: DW] : rdata_b[idx*DW +: DW];
            3:       return d != 0 ? {31'b0, rbusy_n[idx]} : {31'b0, rbusy_b[idx]};
            default: return d != 0 ? ila_n : ila_b;
        endcase
    endfunction

    string kn [5] = '{"ready", "busy_vec", "rdata", "rbusy", "ila_data"};
    exp_t        mon_e;
    logic [31:0] mon_act;

    // Monitor: every expectation queued for this cycle is compared mid-cycle
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            mon_e   = expq.pop_front();
            mon_act = actual(mon_e.kind, mon_e.dut, mon_e.idx);
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s %s port=%0d got=%h want=%h t=%0t", kn[mon_e.kind],
                         mon_e.dut != 0 ? "nobypass" : "bypass", mon_e.idx, mon_act, mon_e.val, $time);
            end
        end
    end

    initial begin
        m_known = '0;
        m_busy  = '0;
        m_run   = 1'b0;
        m_init  = 1'b0;
        m_cnt   = 0;
        rst     = 1'b1;
        idle_in();
        @(posedge clk);
        #1;

        // T1: single reset cycle, random ignored traffic during the sweep
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin rand_in(); cycle(); end
        for (int k = 0; k < D; k++) begin idle_in(); ila_addr = AW'(k); cycle(); end

        // T2: fill with pattern, then reset again part way through the sweep
        for (int k = 0; k < D; k++) begin
            idle_in();
            wena = 2'b01;
            waddr[3:0] = AW'(k);
            wdata[31:0] = 32'hAAAA_AAAA;
            cycle();
        end
        rst = 1'b1; idle_in(); cycle(); rst = 1'b0;
        for (int k = 0; k < 7; k++) begin rand_in(); cycle(); end
        rst = 1'b1; idle_in(); cycle(); rst = 1'b0;
        for (int k = 0; k < 17; k++) begin rand_in(); cycle(); end
        for (int k = 0; k < D; k++) begin idle_in(); ila_addr = AW'(k); cycle(); end

        // T3/T4: both ports hit address 5, higher port wins
        idle_in(); wena = 2'b11; waddr = {4'd5, 4'd5}; wdata = {32'h22, 32'h11}; raddr[3:0] = 4'd5; cycle();
        idle_in(); raddr[3:0] = 4'd5; ila_addr = 4'd5; cycle();

        // T5: set then clear busy on address 3
        idle_in(); sb_set = 1'b1; sb_addr = 4'd3; cycle();
        idle_in(); raddr[7:4] = 4'd3; cycle();
        idle_in(); wena = 2'b01; wclr = 2'b01; waddr[3:0] = 4'd3; wdata[31:0] = 32'h33; raddr[7:4] = 4'd3; cycle();
        idle_in(); raddr[7:4] = 4'd3; cycle();

        // T6: set wins over same-cycle clear; wclr without wena does nothing
        idle_in(); sb_set = 1'b1; sb_addr = 4'd9; wena = 2'b10; wclr = 2'b10; waddr[7:4] = 4'd9; wdata[63:32] = 32'h99; cycle();
        idle_in(); wclr = 2'b11; waddr = {4'd9, 4'd9}; raddr = {4'd9, 4'd9, 4'd9}; cycle();
        idle_in(); raddr[3:0] = 4'd9; cycle();

        // Random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            rand_in();
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin idle_in(); cycle(); end

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0 pending expectations", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
